// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM bundle: ID/EX register outputs and flush in, stall and
// registered EX/MEM results out. The master side is the pipeline front end
// (or a bench); the slave side is the execute stage itself.
interface ex_mem_stage_if;
  logic        in_valid;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npcout;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] sign_extendout;
  logic [4:0]  instrout_2021;
  logic [4:0]  instrout_1511;
  logic        flush;
  logic        stall;
  logic [1:0]  exm_wb_ctl;
  logic [2:0]  exm_m_ctl;
  logic [31:0] exm_branch_target;
  logic        exm_zero;
  logic [31:0] exm_alu_result;
  logic [31:0] exm_wdata;
  logic [4:0]  exm_dest;
  logic        exm_valid;

  modport master (
    output in_valid, wb_ctlout, m_ctlout, regdst, alusrc, aluop, npcout,
           rdata1out, rdata2out, sign_extendout, instrout_2021,
           instrout_1511, flush,
    input  stall, exm_wb_ctl, exm_m_ctl, exm_branch_target, exm_zero,
           exm_alu_result, exm_wdata, exm_dest, exm_valid
  );

  modport slave (
    input  in_valid, wb_ctlout, m_ctlout, regdst, alusrc, aluop, npcout,
           rdata1out, rdata2out, sign_extendout, instrout_2021,
           instrout_1511, flush,
    output stall, exm_wb_ctl, exm_m_ctl, exm_branch_target, exm_zero,
           exm_alu_result, exm_wdata, exm_dest, exm_valid
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage + EX/MEM register: ALU, zero flag, branch target, dest select.
// Latency: 1 edge for single-cycle ops; 32 edges for mult (E0 accept, E32 result).
// Backpressure: stall holds the front end during a multiply; built only when
// EX_MUL_EN is defined, otherwise mult funct yields 0 and stall is tied low.
module ex_mem_stage (
  input  logic         clock,
  input  logic         reset,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_NONE
  } op_t;

  op_t         w_op;
  logic [31:0] w_opb;
  logic [31:0] w_result;
  logic [31:0] w_target;
  logic [4:0]  w_dest;

  logic [1:0]  r_wb;
  logic [2:0]  r_m;
  logic [31:0] r_target;
  logic        r_zero;
  logic [31:0] r_result;
  logic [31:0] r_wdata;
  logic [4:0]  r_dest;
  logic        r_valid;

  assign w_opb    = bus.alusrc ? bus.sign_extendout : bus.rdata2out;
  assign w_target = bus.npcout + {bus.sign_extendout[29:0], 2'b00};
  assign w_dest   = bus.regdst ? bus.instrout_1511 : bus.instrout_2021;

  // ALU control: aluop class, then funct for R-type
  always_comb begin
    w_op = OP_NONE;
    case (bus.aluop)
      2'b00, 2'b11: w_op = OP_ADD;
      2'b01:        w_op = OP_SUB;
      default: begin
        case (bus.sign_extendout[5:0])
          6'b100000: w_op = OP_ADD;
          6'b100010: w_op = OP_SUB;
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b101010: w_op = OP_SLT;
`ifdef EX_MUL_EN
          6'b011000: w_op = OP_MUL;
`endif
          default:   w_op = OP_NONE;
        endcase
      end
    endcase
  end

  // Single-cycle ALU; mult and unsupported functs produce 0 here
  always_comb begin
    w_result = 32'd0;
    case (w_op)
      OP_ADD:  w_result = bus.rdata1out + w_opb;
      OP_SUB:  w_result = bus.rdata1out - w_opb;
      OP_AND:  w_result = bus.rdata1out & w_opb;
      OP_OR:   w_result = bus.rdata1out | w_opb;
      OP_SLT:  w_result = {31'd0, ($signed(bus.rdata1out) < $signed(w_opb))};
      default: w_result = 32'd0;
    endcase
  end

  assign bus.exm_wb_ctl        = r_wb;
  assign bus.exm_m_ctl         = r_m;
  assign bus.exm_branch_target = r_target;
  assign bus.exm_zero          = r_zero;
  assign bus.exm_alu_result    = r_result;
  assign bus.exm_wdata         = r_wdata;
  assign bus.exm_dest          = r_dest;
  assign bus.exm_valid         = r_valid;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [1:0]  r_l_wb;
  logic [2:0]  r_l_m;
  logic [31:0] r_l_target;
  logic [31:0] r_l_wdata;
  logic [4:0]  r_l_dest;
  logic        w_start;
  logic [31:0] w_acc_next;

  assign w_start    = bus.in_valid && (w_op == OP_MUL);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  // Reset and flush both kill a pending start, so neither may stall the front end
  assign bus.stall  = !reset && !bus.flush &&
                      (((r_state == S_IDLE) && w_start) || (r_state == S_MUL));

  // Pipeline register plus shift-add multiply FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_acc      <= 32'd0;
      r_mcand    <= 32'd0;
      r_mplier   <= 32'd0;
      r_l_wb     <= 2'd0;
      r_l_m      <= 3'd0;
      r_l_target <= 32'd0;
      r_l_wdata  <= 32'd0;
      r_l_dest   <= 5'd0;
      r_wb       <= 2'd0;
      r_m        <= 3'd0;
      r_target   <= 32'd0;
      r_zero     <= 1'b0;
      r_result   <= 32'd0;
      r_wdata    <= 32'd0;
      r_dest     <= 5'd0;
      r_valid    <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mcand    <= bus.rdata1out;
            r_mplier   <= w_opb;
            r_acc      <= 32'd0;
            r_cnt      <= 5'd0;
            r_l_wb     <= bus.wb_ctlout;
            r_l_m      <= bus.m_ctlout;
            r_l_target <= w_target;
            r_l_wdata  <= bus.rdata2out;
            r_l_dest   <= w_dest;
            r_valid    <= 1'b0;
            r_state    <= S_MUL;
          end else begin
            r_wb     <= bus.wb_ctlout;
            r_m      <= bus.m_ctlout;
            r_target <= w_target;
            r_zero   <= (w_result == 32'd0);
            r_result <= w_result;
            r_wdata  <= bus.rdata2out;
            r_dest   <= w_dest;
            r_valid  <= bus.in_valid;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_wb     <= r_l_wb;
            r_m      <= r_l_m;
            r_target <= r_l_target;
            r_zero   <= (w_acc_next == 32'd0);
            r_result <= w_acc_next;
            r_wdata  <= r_l_wdata;
            r_dest   <= r_l_dest;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // ID/EX still shows the consumed mult this cycle; ignore it
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign bus.stall = 1'b0;

  // Pipeline register: every op completes in one edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb     <= 2'd0;
      r_m      <= 3'd0;
      r_target <= 32'd0;
      r_zero   <= 1'b0;
      r_result <= 32'd0;
      r_wdata  <= 32'd0;
      r_dest   <= 5'd0;
      r_valid  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else begin
      r_wb     <= bus.wb_ctlout;
      r_m      <= bus.m_ctlout;
      r_target <= w_target;
      r_zero   <= (w_result == 32'd0);
      r_result <= w_result;
      r_wdata  <= bus.rdata2out;
      r_dest   <= w_dest;
      r_valid  <= bus.in_valid;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for single-cycle ops,
// hand sequences for flush, async reset and (with EX_MUL_EN) the multiplier.
module tb_ex_mem_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [4:0]  r2021;
    logic [4:0]  r1511;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_bt;
    logic [4:0]  e_dest;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid       = v.vld;
    bus.wb_ctlout      = v.wb;
    bus.m_ctlout       = v.m;
    bus.regdst         = v.regdst;
    bus.alusrc         = v.alusrc;
    bus.aluop          = v.aluop;
    bus.npcout         = v.npc;
    bus.rdata1out      = v.a;
    bus.rdata2out      = v.b;
    bus.sign_extendout = v.se;
    bus.instrout_2021  = v.r2021;
    bus.instrout_1511  = v.r1511;
  endtask

  // Simple op: regdst=0 so dest = instrout_2021 = 5'd9, npc=0, controls 0
  task automatic drive_op(input logic vld, input logic [1:0] aluop,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] se);
    vec_t v;
    v = '{vld, 2'd0, 3'd0, 1'b0, 1'b0, aluop, 32'd0, a, b, se, 5'd9, 5'd1,
          32'd0, 1'b0, 32'd0, 5'd0};
    drive(v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res"},   bus.exm_alu_result, 32'd0);
    chk({tag, "_bt"},    bus.exm_branch_target, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.exm_valid}, 32'd0);
    chk({tag, "_ctl"},   {27'd0, bus.exm_wb_ctl, bus.exm_m_ctl}, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            vld wb  m    rd   as   aluop  npc           a             b             se            r20   r15    res           z     bt            dest
    vec[0]  = '{1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 2'b10, 32'h1000, 32'd3,        32'd4,        32'h20,       5'd2,  5'd9,  32'd7,        1'b0, 32'h1080, 5'd2};
    vec[1]  = '{1'b1, 2'd2, 3'd5, 1'b1, 1'b0, 2'b10, 32'h0,    32'd5,        32'd5,        32'h22,       5'd4,  5'd3,  32'd0,        1'b1, 32'h88,   5'd3};
    vec[2]  = '{1'b1, 2'd3, 3'd1, 1'b0, 1'b1, 2'b01, 32'h100,  32'd10,       32'h55,       32'hFFFFFFFF, 5'd6,  5'd8,  32'd11,       1'b0, 32'hFC,   5'd6};
    vec[3]  = '{1'b1, 2'd0, 3'd7, 1'b1, 1'b0, 2'b10, 32'h200,  32'hFFFFFFFF, 32'd1,        32'h2A,       5'd1,  5'd7,  32'd1,        1'b0, 32'h2A8,  5'd7};
    vec[4]  = '{1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 2'b10, 32'h300,  32'd1,        32'hFFFFFFFF, 32'h2A,       5'd12, 5'd13, 32'd0,        1'b1, 32'h3A8,  5'd12};
    vec[5]  = '{1'b1, 2'd2, 3'd3, 1'b1, 1'b0, 2'b10, 32'h10,   32'hF0F01234, 32'hFF00FF00, 32'h24,       5'd0,  5'd31, 32'hF0001200, 1'b0, 32'hA0,   5'd31};
    vec[6]  = '{1'b1, 2'd3, 3'd4, 1'b0, 1'b0, 2'b10, 32'h20,   32'h0F000001, 32'h00F00010, 32'h25,       5'd17, 5'd18, 32'h0FF00011, 1'b0, 32'hB4,   5'd17};
    vec[7]  = '{1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 32'h40,   32'd5,        32'd6,        32'h0,        5'd20, 5'd21, 32'd0,        1'b1, 32'h40,   5'd21};
    vec[8]  = '{1'b1, 2'd1, 3'd1, 1'b0, 1'b1, 2'b00, 32'h0,    32'h7FFFFFFF, 32'h99,       32'h10,       5'd5,  5'd6,  32'h8000000F, 1'b0, 32'h40,   5'd5};
    vec[9]  = '{1'b1, 2'd2, 3'd2, 1'b1, 1'b0, 2'b11, 32'h44,   32'hFFFFFFFF, 32'd1,        32'h0,        5'd9,  5'd10, 32'd0,        1'b1, 32'h44,   5'd10};
    vec[10] = '{1'b0, 2'd3, 3'd7, 1'b0, 1'b0, 2'b00, 32'h8,    32'd1,        32'd2,        32'h0,        5'd11, 5'd12, 32'd3,        1'b0, 32'h8,    5'd11};
    vec[11] = '{1'b1, 2'd0, 3'd6, 1'b1, 1'b0, 2'b01, 32'h1000, 32'd2,        32'd3,        32'hFFFFFFFE, 5'd14, 5'd15, 32'hFFFFFFFF, 1'b0, 32'hFF8,  5'd15};
    vec[12] = '{1'b1, 2'd1, 3'd5, 1'b0, 1'b1, 2'b10, 32'h0,    32'h10,       32'h77,       32'h20,       5'd3,  5'd4,  32'h30,       1'b0, 32'h80,   5'd3};

    bus.flush = 1'b0;
    drive_op(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);

    // Reset state
    #2;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single-cycle vector table
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall}, 32'd0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_res", i),   bus.exm_alu_result, vec[i].e_res);
      chk($sformatf("v%0d_zero", i),  {31'd0, bus.exm_zero}, {31'd0, vec[i].e_zero});
      chk($sformatf("v%0d_bt", i),    bus.exm_branch_target, vec[i].e_bt);
      chk($sformatf("v%0d_dest", i),  {27'd0, bus.exm_dest}, {27'd0, vec[i].e_dest});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.exm_valid}, {31'd0, vec[i].vld});
      chk($sformatf("v%0d_wdata", i), bus.exm_wdata, vec[i].b);
      chk($sformatf("v%0d_ctl", i),   {27'd0, bus.exm_wb_ctl, bus.exm_m_ctl},
          {27'd0, vec[i].wb, vec[i].m});
    end

`ifndef EX_MUL_EN
    // Without the multiplier, mult funct is unsupported: 0 in one cycle
    @(negedge clock);
    drive_op(1'b1, 2'b10, 32'd3, 32'd4, 32'h18);
    #1;
    chk("nomul_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clock);
    #1;
    chk("nomul_res",   bus.exm_alu_result, 32'd0);
    chk("nomul_zero",  {31'd0, bus.exm_zero}, 32'd1);
    chk("nomul_valid", {31'd0, bus.exm_valid}, 32'd1);
`endif

    // Flush squashes the presented instruction
    @(negedge clock);
    drive_op(1'b1, 2'b00, 32'd1, 32'd1, 32'h0);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clock);
    #1;
    chk("flush_valid", {31'd0, bus.exm_valid}, 32'd0);
    @(negedge clock);
    bus.flush = 1'b0;
    drive_op(1'b1, 2'b00, 32'd8, 32'd9, 32'h4);
    @(posedge clock);
    #1;
    chk("postflush_valid", {31'd0, bus.exm_valid}, 32'd1);
    chk("postflush_res",   bus.exm_alu_result, 32'd17);
    chk("postflush_bt",    bus.exm_branch_target, 32'h10);

`ifdef EX_MUL_EN
    begin
      int n;
      // Full multiply: stall for 33 cycles, result at E32, bubble at E33
      @(negedge clock);
      drive_op(1'b1, 2'b10, 32'h10000, 32'h30001, 32'h18);
      #1;
      n = 0;
      while (bus.stall && n < 100) begin
        n++;
        @(posedge clock);
        #1;
      end
      chk("mul_stall_cycles", n, 33);
      chk("mul_res",   bus.exm_alu_result, 32'h10000);
      chk("mul_valid", {31'd0, bus.exm_valid}, 32'd1);
      chk("mul_zero",  {31'd0, bus.exm_zero}, 32'd0);
      chk("mul_dest",  {27'd0, bus.exm_dest}, 32'd9);
      chk("mul_done_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clock);
      #1;
      chk("mul_e33_valid", {31'd0, bus.exm_valid}, 32'd0);
      drive_op(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
      #1;
      chk("mul_e33_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clock);
      #1;
      chk("mul_norestart_valid", {31'd0, bus.exm_valid}, 32'd0);
      chk("mul_norestart_stall", {31'd0, bus.stall}, 32'd0);

      // Multiply flushed at E10, then an add completes normally
      @(negedge clock);
      drive_op(1'b1, 2'b10, 32'd7, 32'd9, 32'h18);
      repeat (10) @(posedge clock);
      @(negedge clock);
      chk("mulflush_busy_stall", {31'd0, bus.stall}, 32'd1);
      bus.flush = 1'b1;
      #1;
      chk("mulflush_stall_forced", {31'd0, bus.stall}, 32'd0);
      @(posedge clock);
      #1;
      bus.flush = 1'b0;
      drive_op(1'b1, 2'b00, 32'd2, 32'd3, 32'h0);
      #1;
      chk("mulflush_valid", {31'd0, bus.exm_valid}, 32'd0);
      chk("mulflush_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clock);
      #1;
      chk("mulflush_add_valid", {31'd0, bus.exm_valid}, 32'd1);
      chk("mulflush_add_res",   bus.exm_alu_result, 32'd5);

      // Reset asserted mid-multiply acts immediately
      @(negedge clock);
      drive_op(1'b1, 2'b10, 32'd3, 32'd3, 32'h18);
      repeat (10) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("mulreset");
      @(negedge clock);
      drive_op(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
      reset = 1'b0;
    end
`else
    // Async reset mid-cycle clears registered outputs before any edge
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("areset");
    @(negedge clock);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
